// File: rtl/rgmii_pkg.sv
// Shared types for the UDP transmit path: arbiter state encoding and pad filler byte.
package rgmii_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_PAD,
    ST_DROP
  } arb_state_e;

  localparam logic [7:0] PAD_BYTE = 8'h00;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns a one-hot grant for the first requester
// found when searching upward from the slot after the last grant.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  grant_o
);

  logic [IW-1:0] idx;
  logic          found;
  int            pos;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    pos     = 0;
    for (int i = 1; i <= N; i++) begin
      pos = int'(last_i) + i;
      if (pos >= N) pos = pos - N;
      idx = IW'(pos);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Round-robin multiplexer of AXI-Stream payload sources onto one packet-generator stream,
// forcing every packet to its configured length by zero padding or dropping surplus beats.
module udp_tx_arbiter
  import rgmii_pkg::*;
#(
  parameter int NUM_SRC         = 4,
  parameter int AXIS_DATA_WIDTH = 8,
  parameter int PAYLOAD_WIDTH   = 11
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  input  logic [NUM_SRC-1:0]                 s_tvalid_i,
  output logic [NUM_SRC-1:0]                 s_tready_o,
  input  logic [NUM_SRC-1:0]                 s_tlast_i,
  input  logic [NUM_SRC*AXIS_DATA_WIDTH-1:0] s_tdata_i,
  input  logic [NUM_SRC*16-1:0]              src_port_i,
  input  logic [NUM_SRC*PAYLOAD_WIDTH-1:0]   src_payload_bytes_i,
  output logic                               m_tvalid_o,
  input  logic                               m_tready_i,
  output logic                               m_tlast_o,
  output logic [AXIS_DATA_WIDTH-1:0]         m_tdata_o,
  output logic [15:0]                        host_port_o,
  output logic [PAYLOAD_WIDTH-1:0]           payload_bytes_o,
  output logic [NUM_SRC-1:0]                 grant_o,
  output logic                               len_err_o
);

  localparam int IW = $clog2(NUM_SRC);

  arb_state_e                 state_q, state_d;
  logic [NUM_SRC-1:0]         grant_q, grant_d;
  logic [IW-1:0]              lastIdx_q, lastIdx_d;
  logic [PAYLOAD_WIDTH-1:0]   cnt_q, cnt_d;
  logic [15:0]                hostPort_q, hostPort_d;
  logic [PAYLOAD_WIDTH-1:0]   payloadLen_q, payloadLen_d;
  logic                       lenErr_q, lenErr_d;

  logic [NUM_SRC-1:0]         arbGrant;
  logic [IW-1:0]              arbIdx;
  logic [15:0]                arbPort;
  logic [PAYLOAD_WIDTH-1:0]   arbLen;
  logic                       selValid, selLast, cntIsOne;
  logic [AXIS_DATA_WIDTH-1:0] selData;

  rr_arbiter #(.N(NUM_SRC), .IW(IW)) u_rr (
    .req_i   (s_tvalid_i),
    .last_i  (lastIdx_q),
    .grant_o (arbGrant)
  );

  // Fields of the arbitration winner and of the currently granted source.
  always_comb begin
    arbIdx   = '0;
    arbPort  = '0;
    arbLen   = '0;
    selValid = 1'b0;
    selLast  = 1'b0;
    selData  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (arbGrant[i]) begin
        arbIdx  = IW'(i);
        arbPort = src_port_i[i*16 +: 16];
        arbLen  = src_payload_bytes_i[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
      end
      if (grant_q[i]) begin
        selValid = s_tvalid_i[i];
        selLast  = s_tlast_i[i];
        selData  = s_tdata_i[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
      end
    end
  end

  assign cntIsOne = (cnt_q == PAYLOAD_WIDTH'(1));

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    lastIdx_d    = lastIdx_q;
    cnt_d        = cnt_q;
    hostPort_d   = hostPort_q;
    payloadLen_d = payloadLen_q;
    lenErr_d     = 1'b0;
    s_tready_o   = '0;
    m_tvalid_o   = 1'b0;
    m_tlast_o    = 1'b0;
    m_tdata_o    = '0;

    case (state_q)
      ST_IDLE: begin
        if (|s_tvalid_i) begin
          grant_d      = arbGrant;
          lastIdx_d    = arbIdx;
          hostPort_d   = arbPort;
          // A zero-length request still produces a single beat.
          payloadLen_d = (arbLen == '0) ? PAYLOAD_WIDTH'(1) : arbLen;
          cnt_d        = (arbLen == '0) ? PAYLOAD_WIDTH'(1) : arbLen;
          state_d      = ST_FWD;
        end
      end
      ST_FWD: begin
        m_tvalid_o = selValid;
        m_tdata_o  = selData;
        m_tlast_o  = cntIsOne;
        s_tready_o = grant_q & {NUM_SRC{m_tready_i}};
        if (selValid && m_tready_i) begin
          if (cnt_q != '0) cnt_d = cnt_q - PAYLOAD_WIDTH'(1);
          if (selLast && cntIsOne) begin
            state_d = ST_IDLE;
            grant_d = '0;
          end else if (selLast) begin
            lenErr_d = 1'b1;
            state_d  = ST_PAD;
          end else if (cntIsOne) begin
            lenErr_d = 1'b1;
            state_d  = ST_DROP;
          end
        end
      end
      ST_PAD: begin
        m_tvalid_o = 1'b1;
        m_tdata_o  = AXIS_DATA_WIDTH'(PAD_BYTE);
        m_tlast_o  = cntIsOne;
        if (m_tready_i) begin
          if (cnt_q != '0) cnt_d = cnt_q - PAYLOAD_WIDTH'(1);
          if (cntIsOne) begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end
      end
      ST_DROP: begin
        s_tready_o = grant_q;
        if (selValid && selLast) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      lastIdx_q    <= IW'(NUM_SRC - 1);
      cnt_q        <= '0;
      hostPort_q   <= '0;
      payloadLen_q <= '0;
      lenErr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      lastIdx_q    <= lastIdx_d;
      cnt_q        <= cnt_d;
      hostPort_q   <= hostPort_d;
      payloadLen_q <= payloadLen_d;
      lenErr_q     <= lenErr_d;
    end
  end

  assign grant_o         = grant_q;
  assign host_port_o     = hostPort_q;
  assign payload_bytes_o = payloadLen_q;
  assign len_err_o       = lenErr_q;

endmodule
